// File: rtl/halut_decoder_ctrl.sv
// halut_decoder_ctrl: job sequencer placed in front of one halut_decoder.
// A job first streams C*K FP16 LUT entries into the decoder write port
// (LOAD), then feeds C k-indices per row (RUN), gives the decoder one extra
// enabled cycle to emit the last row (FLUSH) and finally drains the
// outstanding results (WAIT). Each row produces one FP32 result through a
// single-entry valid/ready buffer.
module halut_decoder_ctrl #(
    parameter int unsigned K              = 16,
    parameter int unsigned C              = 32,
    parameter int unsigned DataTypeWidth  = 16,
    parameter int unsigned RowCntWidth    = 16,
    parameter int unsigned TotalAddrWidth = $clog2(C * K),
    parameter int unsigned CAddrWidth     = $clog2(C),
    parameter int unsigned TreeDepth      = $clog2(K)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [RowCntWidth-1:0]    num_rows_i,
    input  logic [DataTypeWidth-1:0]  lut_wdata_i,
    input  logic                      lut_wvalid_i,
    output logic                      lut_wready_o,
    input  logic [TreeDepth-1:0]      k_i,
    input  logic                      k_valid_i,
    output logic                      k_ready_o,
    output logic [TotalAddrWidth-1:0] dec_waddr_o,
    output logic [DataTypeWidth-1:0]  dec_wdata_o,
    output logic                      dec_we_o,
    output logic [CAddrWidth-1:0]     dec_c_addr_o,
    output logic [TreeDepth-1:0]      dec_k_addr_o,
    output logic                      dec_en_o,
    input  logic [31:0]               dec_result_i,
    input  logic                      dec_valid_i,
    output logic [31:0]               res_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic                      busy_o
);

    // Handshake semantics for the LUT, index and result streams: a transfer
    // takes place on each rising clk_i edge where valid and ready are both
    // high. The valid side holds its data stable until that edge; a ready
    // never depends on the valid of its own stream.

    localparam logic [TotalAddrWidth-1:0] LastAddr = TotalAddrWidth'(C * K - 1);
    localparam logic [CAddrWidth-1:0]     LastC    = CAddrWidth'(C - 1);
    localparam logic [RowCntWidth-1:0]    OneRow   = RowCntWidth'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        WAIT  = 3'd4
    } state_e;

    state_e                    state_q;
    state_e                    state_d;

    logic [TotalAddrWidth-1:0] load_cnt_q;
    logic [CAddrWidth-1:0]     c_cnt_q;
    logic [RowCntWidth-1:0]    rows_q;
    logic [1:0]                pending_q;
    logic                      dec_valid_q;
    logic [31:0]               res_q;
    logic                      res_valid_q;

    logic                      lut_fire;
    logic                      k_ready;
    logic                      k_fire;
    logic                      last_entry;
    logic                      row_end;
    logic                      row_done;
    logic                      last_row;
    logic                      rise;
    logic                      capture;
    logic                      res_pop;

    // Handshake and event decode shared by the FSM and the datapath.
    always_comb begin
        lut_fire   = (state_q == LOAD) && lut_wvalid_i;
        // Hold off new indices while a result sits unread: the next row start
        // would otherwise make the decoder emit into a full buffer.
        k_ready    = (state_q == RUN) && !(res_valid_q && !res_ready_i);
        k_fire     = k_ready && k_valid_i;
        last_entry = (load_cnt_q == LastAddr);
        row_end    = (c_cnt_q == LastC);
        row_done   = k_fire && row_end;
        last_row   = (rows_q == OneRow);
        rise       = dec_valid_i && !dec_valid_q;
        // A rise with nothing pending is the stale output that the first
        // enabled cycle of a job flushes out of the decoder; it is dropped.
        capture    = rise && (pending_q != 2'd0) && !res_valid_q;
        res_pop    = res_valid_q && res_ready_i;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (lut_fire && last_entry) begin
                    state_d = (rows_q == '0) ? IDLE : RUN;
                end
            end
            RUN: begin
                if (row_done && last_row) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if ((pending_q == 2'd0) && !res_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: decoder write port, decoder lookup port and stream readies.
    always_comb begin
        lut_wready_o = (state_q == LOAD);
        k_ready_o    = k_ready;
        dec_we_o     = lut_fire;
        dec_waddr_o  = '0;
        dec_wdata_o  = '0;
        dec_en_o     = 1'b0;
        dec_c_addr_o = '0;
        dec_k_addr_o = '0;
        busy_o       = (state_q != IDLE);
        if (lut_fire) begin
            dec_waddr_o = load_cnt_q;
            dec_wdata_o = lut_wdata_i;
        end
        if (k_fire) begin
            dec_en_o     = 1'b1;
            dec_c_addr_o = c_cnt_q;
            dec_k_addr_o = k_i;
        end else if (state_q == FLUSH) begin
            // Parking the decoder at the last codebook makes it emit the
            // final row now and restart its accumulator on the next job.
            dec_en_o     = 1'b1;
            dec_c_addr_o = LastC;
            dec_k_addr_o = '0;
        end
    end

    // LUT write address counter; clears after the last entry of a load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cnt_q <= '0;
        end else if (lut_fire) begin
            load_cnt_q <= last_entry ? '0 : load_cnt_q + TotalAddrWidth'(1);
        end
    end

    // Codebook counter; wraps at the end of every row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_cnt_q <= '0;
        end else if (k_fire) begin
            c_cnt_q <= row_end ? '0 : c_cnt_q + CAddrWidth'(1);
        end
    end

    // Rows remaining in the job; loaded at start, counted down per row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            rows_q <= num_rows_i;
        end else if (row_done) begin
            rows_q <= rows_q - OneRow;
        end
    end

    // Rows fully issued to the decoder whose result has not been captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 2'd0;
        end else begin
            case ({row_done, capture})
                2'b10:   pending_q <= pending_q + 2'd1;
                2'b01:   pending_q <= pending_q - 2'd1;
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Delayed decoder valid for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_q <= 1'b0;
        end else begin
            dec_valid_q <= dec_valid_i;
        end
    end

    // Single-entry result buffer; a capture wins over a same-cycle pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else if (capture) begin
            res_q       <= dec_result_i;
            res_valid_q <= 1'b1;
        end else if (res_pop) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;

    // The index stall guarantees the buffer is empty whenever a real row
    // result arrives; anything else would silently lose a row.
    buffer_free_on_rise: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (rise && (pending_q != 2'd0)) |-> !res_valid_q
    );

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// tb_halut_decoder_ctrl: directed bench for halut_decoder_ctrl with a small
// behavioural halut_decoder (LUT memory plus integer-valued accumulator).
module tb_halut_decoder_ctrl;
  localparam int K  = 16;
  localparam int C  = 32;
  localparam int DW = 16;
  localparam int RW = 16;
  localparam int AW = 9;
  localparam int CW = 5;
  localparam int TD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [RW-1:0] num_rows;
  logic [DW-1:0] lut_wdata;
  logic          lut_wvalid;
  logic          lut_wready;
  logic [TD-1:0] k;
  logic          k_valid;
  logic          k_ready;
  logic [AW-1:0] dec_waddr;
  logic [DW-1:0] dec_wdata;
  logic          dec_we;
  logic [CW-1:0] dec_c_addr;
  logic [TD-1:0] dec_k_addr;
  logic          dec_en;
  logic [31:0]   dec_result;
  logic          dec_valid;
  logic [31:0]   res;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  halut_decoder_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .num_rows_i   (num_rows),
    .lut_wdata_i  (lut_wdata),
    .lut_wvalid_i (lut_wvalid),
    .lut_wready_o (lut_wready),
    .k_i          (k),
    .k_valid_i    (k_valid),
    .k_ready_o    (k_ready),
    .dec_waddr_o  (dec_waddr),
    .dec_wdata_o  (dec_wdata),
    .dec_we_o     (dec_we),
    .dec_c_addr_o (dec_c_addr),
    .dec_k_addr_o (dec_k_addr),
    .dec_en_o     (dec_en),
    .dec_result_i (dec_result),
    .dec_valid_i  (dec_valid),
    .res_o        (res),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .busy_o       (busy)
  );

  // ---------------- number helpers ----------------
  function automatic int msb_of(input int unsigned n);
    int m;
    m = 0;
    for (int i = 0; i < 32; i++) if (n[i]) m = i;
    return m;
  endfunction

  function automatic logic [15:0] int_to_fp16(input int unsigned n);
    int e;
    logic [31:0] sh;
    if (n == 0) return 16'd0;
    e  = msb_of(n);
    sh = n << (10 - e);
    return {1'b0, 5'(e + 15), sh[9:0]};
  endfunction

  function automatic int unsigned fp16_to_int(input logic [15:0] h);
    logic [4:0]  ex;
    logic [31:0] sig;
    int e;
    ex  = h[14:10];
    sig = {21'd0, 1'b1, h[9:0]};
    if (ex < 5'd15 || ex > 5'd25) return 0;
    e = int'(ex) - 15;
    return sig >> (10 - e);
  endfunction

  function automatic logic [31:0] int_to_fp32(input int unsigned n);
    int e;
    logic [31:0] sh;
    if (n == 0) return 32'd0;
    e  = msb_of(n);
    sh = (e <= 23) ? (n << (23 - e)) : (n >> (e - 23));
    return {1'b0, 8'(e + 127), sh[22:0]};
  endfunction

  // ---------------- decoder model ----------------
  // Emits the finished row one cycle after an enabled cycle that follows
  // codebook C-1, then restarts its sum with the current entry.
  logic [15:0]  lut_mem [C*K];
  int unsigned  acc;
  logic [CW-1:0] m_caddr_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid  <= 1'b0;
      dec_result <= 32'd0;
      acc        <= 0;
      m_caddr_q  <= CW'(C - 1);
    end else begin
      if (dec_we) lut_mem[dec_waddr] <= dec_wdata;
      if (dec_en) begin
        if (m_caddr_q == CW'(C - 1)) begin
          dec_result <= int_to_fp32(acc);
          dec_valid  <= 1'b1;
          acc        <= fp16_to_int(lut_mem[{dec_c_addr, dec_k_addr}]);
        end else begin
          dec_valid  <= 1'b0;
          acc        <= acc + fp16_to_int(lut_mem[{dec_c_addr, dec_k_addr}]);
        end
        m_caddr_q <= dec_c_addr;
      end else begin
        dec_valid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  int res_count = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [3:0]  base;
    logic [3:0]  step;
    logic [31:0] exp_res;
  } row_vec_t;
  row_vec_t vec [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        res_count++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got %h, required no result", res);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("row_result", res, e);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_job(input int rows);
    @(posedge clk); #1;
    start    = 1'b1;
    num_rows = RW'(rows);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // mode 0: raw index, 1: all 1.0, 2: 1.0 + k
  task automatic load_lut(input int mode, input bit gaps);
    for (int i = 0; i < C * K; i++) begin
      if (gaps && (i % 100) == 50) begin
        lut_wvalid = 1'b0;
        @(negedge clk);
        check("load_gap_we", 32'(dec_we), 32'd0);
        @(posedge clk); #1;
      end
      lut_wvalid = 1'b1;
      lut_wdata  = (mode == 0) ? 16'(i) : (mode == 1) ? 16'h3C00 : int_to_fp16(32'((i % K) + 1));
      @(negedge clk);
      check("load_we", 32'(dec_we), 32'd1);
      check("load_waddr", 32'(dec_waddr), 32'(i));
      if (gaps) check("load_wdata", 32'(dec_wdata), 32'(lut_wdata));
      @(posedge clk); #1;
    end
    lut_wvalid = 1'b0;
  endtask

  task automatic send_row(input logic [3:0] base, input logic [3:0] step, input int ncodes,
                          input bit gaps, output int stalls);
    logic [3:0] kk;
    bit done;
    int n;
    stalls = 0;
    for (int c = 0; c < ncodes; c++) begin
      kk = 4'(int'(base) + int'(step) * c);
      if (gaps && $urandom_range(0, 3) == 0) begin
        k_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("gap_en", 32'(dec_en), 32'd0);
          @(posedge clk); #1;
        end
      end
      k_valid = 1'b1;
      k       = kk;
      done    = 1'b0;
      n       = 0;
      while (!done) begin
        @(negedge clk);
        if (k_ready) begin
          check("run_en", 32'(dec_en), 32'd1);
          check("run_caddr", 32'(dec_c_addr), 32'(c));
          check("run_kaddr", 32'(dec_k_addr), 32'(kk));
          done = 1'b1;
        end else begin
          stalls++;
          check("stall_en", 32'(dec_en), 32'd0);
        end
        n++;
        @(posedge clk); #1;
        if (!done && n >= 200) begin
          compared++;
          mismatched++;
          $display("FAIL k_accept_timeout: got no accept in 200 cycles at c=%0d, required accept", c);
          k_valid = 1'b0;
          return;
        end
      end
    end
    k_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy) begin
      @(posedge clk); #1;
      n++;
      if (n >= 2000) begin
        compared++;
        mismatched++;
        $display("FAIL %s: busy still 1 after 2000 cycles, required 0", name);
        return;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int st;
    int tot;
    int c0;
    int n;
    vec[0] = '{base: 4'd0,  step: 4'd0, exp_res: 32'h42000000};  // 32 * 1
    vec[1] = '{base: 4'd3,  step: 4'd0, exp_res: 32'h43000000};  // 32 * 4
    vec[2] = '{base: 4'd0,  step: 4'd1, exp_res: 32'h43880000};  // 2 * (1..16)
    vec[3] = '{base: 4'd15, step: 4'd0, exp_res: 32'h44000000};  // 32 * 16
    vec[4] = '{base: 4'd0,  step: 4'd2, exp_res: 32'h43800000};  // 4 * (1,3,..,15)

    start = 1'b0; num_rows = '0; lut_wdata = '0; lut_wvalid = 1'b0;
    k = '0; k_valid = 1'b0; res_ready = 1'b0;
    fork monitor(); join_none

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lut_wready", 32'(lut_wready), 32'd0);
    check("rst_k_ready", 32'(k_ready), 32'd0);
    check("rst_dec_we", 32'(dec_we), 32'd0);
    check("rst_dec_en", 32'(dec_en), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res", res, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // streams are not acknowledged in IDLE
    @(posedge clk); #1;
    lut_wvalid = 1'b1; k_valid = 1'b1; lut_wdata = 16'hABCD;
    @(negedge clk);
    check("idle_lut_wready", 32'(lut_wready), 32'd0);
    check("idle_k_ready", 32'(k_ready), 32'd0);
    check("idle_dec_we", 32'(dec_we), 32'd0);
    check("idle_dec_en", 32'(dec_en), 32'd0);
    @(posedge clk); #1;
    lut_wvalid = 1'b0; k_valid = 1'b0;

    // load only
    res_ready = 1'b1;
    c0 = res_count;
    start_job(0);
    load_lut(0, 1'b1);
    @(negedge clk);
    check("load_only_busy_fall", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("load_only_no_result", 32'(res_count - c0), 32'd0);

    // one row, LUT all 1.0, latency and FLUSH drive
    res_ready = 1'b0;
    c0 = res_count;
    start_job(1);
    load_lut(1, 1'b0);
    start = 1'b1; num_rows = RW'(7);   // ignored outside IDLE
    @(posedge clk); #1;
    start = 1'b0;
    send_row(4'd5, 4'd7, C, 1'b0, st);
    exp_q.push_back(32'h42000000);
    @(negedge clk);
    check("flush_en", 32'(dec_en), 32'd1);
    check("flush_caddr", 32'(dec_c_addr), 32'(C - 1));
    check("flush_kaddr", 32'(dec_k_addr), 32'd0);
    check("flush_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat1_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat2_res_valid", 32'(res_valid), 32'd1);
    check("one_row_sum", res, 32'h42000000);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("one_row_idle");
    check("one_row_count", 32'(res_count - c0), 32'd1);

    // three rows back to back
    c0 = res_count;
    tot = 0;
    start_job(3);
    load_lut(2, 1'b0);
    for (int r = 0; r < 3; r++) begin
      send_row(vec[r].base, vec[r].step, C, 1'b0, st);
      exp_q.push_back(vec[r].exp_res);
      tot += st;
    end
    check("b2b_no_bubble", 32'(tot), 32'd0);
    wait_idle("b2b_idle");
    check("b2b_count", 32'(res_count - c0), 32'd3);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // gaps on k_valid and a 20-cycle result stall
    c0 = res_count;
    start_job(5);
    load_lut(2, 1'b0);
    fork
      begin
        for (int r = 0; r < 5; r++) begin
          send_row(vec[r].base, vec[r].step, C, 1'b1, st);
          exp_q.push_back(vec[r].exp_res);
        end
      end
      begin
        n = 0;
        while (!res_valid && n < 3000) begin
          @(posedge clk); #1;
          n++;
        end
        if (!res_valid) begin
          compared++;
          mismatched++;
          $display("FAIL stall_wait_timeout: got no result in 3000 cycles, required one");
        end else begin
          res_ready = 1'b0;
          repeat (20) begin
            @(negedge clk);
            check("stall_res_hold", 32'(res_valid), 32'd1);
            check("stall_k_ready", 32'(k_ready), 32'd0);
            @(posedge clk); #1;
          end
          res_ready = 1'b1;
        end
      end
    join
    wait_idle("stress_idle");
    check("stress_count", 32'(res_count - c0), 32'd5);
    check("stress_queue_empty", 32'(exp_q.size()), 32'd0);

    // two consecutive one-row jobs: job 2 must not see job 1 or its flush
    c0 = res_count;
    start_job(1);
    load_lut(2, 1'b0);
    send_row(vec[3].base, vec[3].step, C, 1'b0, st);
    exp_q.push_back(vec[3].exp_res);
    wait_idle("job1_idle");
    check("job1_count", 32'(res_count - c0), 32'd1);
    start_job(1);
    load_lut(2, 1'b0);
    send_row(vec[0].base, vec[0].step, C, 1'b0, st);
    exp_q.push_back(vec[0].exp_res);
    wait_idle("job2_idle");
    check("job2_count", 32'(res_count - c0), 32'd2);

    // reset in row 1 after c = 10, then a fresh job
    c0 = res_count;
    start_job(2);
    load_lut(2, 1'b0);
    send_row(vec[1].base, vec[1].step, C, 1'b0, st);
    exp_q.push_back(vec[1].exp_res);
    send_row(vec[2].base, vec[2].step, 11, 1'b0, st);
    check("pre_reset_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_k_ready", 32'(k_ready), 32'd0);
    check("mid_rst_dec_en", 32'(dec_en), 32'd0);
    check("mid_rst_dec_caddr", 32'(dec_c_addr), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_res", res, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_idle", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start_job(1);
    load_lut(2, 1'b0);
    send_row(vec[4].base, vec[4].step, C, 1'b0, st);
    exp_q.push_back(vec[4].exp_res);
    wait_idle("after_rst_idle");
    check("after_rst_count", 32'(res_count - c0), 32'd2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at 3 ms, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/halut_decoder_ctrl.md
Name: halut_decoder_ctrl

Overview:
- Sequencer in front of one halut_decoder (K×C LUT plus FP16→FP32 accumulator).
- Runs a job in two phases:
  - LOAD: streams C*K FP16 LUT entries into the decoder's write port at auto-incrementing addresses.
  - RUN: consumes a stream of encoder k-indices (one per codebook, C per row), drives c_addr/k_addr/decoder_i, flushes the accumulator pipeline at job end, and returns one FP32 result per row through a valid/ready buffer.

Parameters:
- K, 16, prototypes per codebook.
- C, 32, codebooks per row.
- DataTypeWidth, 16, LUT entry width.
- RowCntWidth, 16, width of the per-job row count.
- TotalAddrWidth, $clog2(C*K), LUT address width (derived).
- CAddrWidth, $clog2(C), codebook address width (derived).
- TreeDepth, $clog2(K), k-index width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  job start pulse; sampled in IDLE only
- num_rows_i  in  RowCntWidth  rows in job; sampled with start_i; 0 = LUT load only
- lut_wdata_i  in  DataTypeWidth  LUT entry stream data
- lut_wvalid_i  in  1  LUT entry valid
- lut_wready_o  out  1  LUT entry ready
- k_i  in  TreeDepth  encoded prototype index
- k_valid_i  in  1  index valid
- k_ready_o  out  1  index ready
- dec_waddr_o  out  TotalAddrWidth  to decoder waddr_i
- dec_wdata_o  out  DataTypeWidth  to decoder wdata_i
- dec_we_o  out  1  to decoder we_i
- dec_c_addr_o  out  CAddrWidth  to decoder c_addr_i
- dec_k_addr_o  out  TreeDepth  to decoder k_addr_i
- dec_en_o  out  1  to decoder decoder_i
- dec_result_i  in  32  from decoder result_o
- dec_valid_i  in  1  from decoder valid_o
- res_o  out  32  row result (FP32)
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Address, codebook and row counters 0; pending counter 0; result buffer empty.
- FSM states: IDLE, LOAD, RUN, FLUSH, WAIT.
  - IDLE: start_i → LOAD; num_rows_i is latched into the row counter.
  - LOAD:
    - lut_wready_o = 1.
    - Each lut_wvalid_i & lut_wready_o: dec_we_o = 1, dec_wdata_o = lut_wdata_i, dec_waddr_o = load counter (combinational, same cycle); counter increments.
    - Handshake at counter = C*K-1 → RUN, or → IDLE if rows = 0. The counter then clears.
  - RUN:
    - k_ready_o = ~(res_valid_o & ~res_ready_i).
    - On accept: dec_en_o = 1, dec_k_addr_o = k_i, dec_c_addr_o = c counter (same cycle); c counter increments and wraps at C-1 → 0.
    - Accepting c = C-1 increments pending and decrements rows remaining.
    - Accepting the last code of the last row → FLUSH.
    - No accept: dec_en_o = 0 (decoder holds; its valid drops).
  - FLUSH: exactly one cycle, dec_en_o = 1, dec_c_addr_o = C-1, dec_k_addr_o = 0; → WAIT.
    - This lets the decoder emit the final row and parks its caddr_q at C-1, so the next job starts with a cleared accumulator.
  - WAIT: stay until pending = 0 and the result buffer is empty; → IDLE.
- Result capture:
  - rise = dec_valid_i & ~dec_valid_q, with dec_valid_q registered.
  - On rise with pending > 0: res_o ← dec_result_i, res_valid_o ← 1, pending decrements.
  - On rise with pending = 0: ignored. This is the spurious valid produced by the first accept of a job after a FLUSH.
  - res_valid_o clears on res_valid_o & res_ready_i.
  - The k_ready_o stall rule guarantees the buffer is empty when a rise arrives; a rise with the buffer full sets no state and is a design assertion failure.
- Latency:
  - Result of row r appears 2 cycles after the handshake of row r+1's first code, or 2 cycles after FLUSH for the last row.
  - Stalls on k_valid_i only stretch this.
- Boundaries:
  - Back-to-back rows stream with no bubble.
  - start_i outside IDLE is ignored.
  - lut_wvalid_i outside LOAD and k_valid_i outside RUN are not acknowledged.
  - Reset mid-job returns to IDLE; the LUT must be reloaded.
- Widths: pending counter is 2 bits (max 1 outstanding plus 1 in flight); row counter is RowCntWidth.

Test Plan:
- Load only: start with num_rows = 0, stream 512 entries 0..511 → dec_we_o pulses with waddr 0..511 matching data; busy_o falls the cycle after the last handshake; no res_valid_o.
- One row, K=16, C=32, LUT[c][k] = 1.0 (0x3C00), 32 indices without stalls → exactly one res_o = 0x42000000 (32.0), 2 cycles after FLUSH.
- Three rows back-to-back with res_ready_i = 1 → three results in order, no index bubbles, then IDLE.
- Random k_valid_i gaps and res_ready_i held low 20 cycles → k_ready_o low while the buffer is full; all row sums correct; none lost or duplicated.
- Two consecutive one-row jobs → the spurious decoder valid at the start of job 2 is suppressed; job 2 result is uncontaminated by job 1.
- Assert rst_ni mid-RUN (row 1, c = 10) → all outputs 0 next edge, FSM IDLE; a new full job then completes correctly.
